// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared opcode, field positions and fetch FSM encodings
package instruction_fetch_pkg;
  localparam logic [3:0] NOP = 4'h0;
  localparam int INSN_OPCODE_MSB = 27;
  localparam int INSN_OPCODE_LSB = 24;
  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;
  function automatic logic [INSN_OPCODE_MSB:0] nop_bubble();
    logic [INSN_OPCODE_MSB:0] w_b;
    w_b = '0;
    w_b[INSN_OPCODE_MSB:INSN_OPCODE_LSB] = NOP;
    return w_b;
  endfunction
endpackage

// File: rtl/instruction_fetch_ff_async_en.sv
// ff_async_en: D flip-flop bank with enable and asynchronous active-high reset value
module ff_async_en #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iEnable,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ
);
  // load on enable, reset value applied immediately on iReset
  always_ff @(posedge iClock or posedge iReset)
    if (iReset) oQ <= RST_VAL;
    else if (iEnable) oQ <= iD;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC + one-entry fetch register with valid/ready handoff, redirect and halt (optional FETCH_PERF_EN counters)
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int INSN_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 16'd0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] oAddress,
  input  logic [INSN_WIDTH-1:0] iInstruction,
  output logic [INSN_WIDTH-1:0] oInstruction,
  output logic [ADDR_WIDTH-1:0] oInstructionPC,
  output logic                  oValid,
  input  logic                  iReady,
  input  logic                  iBranchTaken,
  input  logic [ADDR_WIDTH-1:0] iBranchTarget,
  input  logic                  iHalt,
  input  logic                  iResume,
  output logic                  oHalted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]           oFetchCount,
  output logic [15:0]           oBubbleCount
`endif
);
  localparam logic [INSN_WIDTH-1:0] BUBBLE = {NOP, {(INSN_WIDTH-4){1'b0}}};
  logic [1:0]            r_state;
  logic [1:0]            w_state_d;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_d;
  logic [INSN_WIDTH-1:0] w_insn_d;
  logic                  w_redirect, w_xfer, w_free, w_fetch;
  assign w_redirect = iBranchTaken && r_state != FETCH_BOOT;
  assign w_xfer     = oValid && iReady;
  assign w_free     = !oValid || iReady;
  assign w_fetch    = !w_redirect && r_state == FETCH_RUN && w_free;
  assign w_pc_d     = w_redirect ? iBranchTarget : r_pc + 1'b1;
  assign w_insn_d   = w_redirect ? BUBBLE : iInstruction;
  assign w_state_d  = r_state == FETCH_BOOT ? FETCH_RUN :
                      r_state == FETCH_RUN  ? ((iHalt && !iBranchTaken) ? FETCH_HALT : FETCH_RUN) :
                      ((iResume && !iHalt) ? FETCH_RUN : FETCH_HALT);
  assign oAddress   = r_pc;
  assign oHalted    = r_state == FETCH_HALT;
  ff_async_en #(.WIDTH(2), .RST_VAL(FETCH_BOOT)) u_state (
    .iClock(Clock), .iReset(Reset), .iEnable(1'b1), .iD(w_state_d), .oQ(r_state));
  ff_async_en #(.WIDTH(ADDR_WIDTH), .RST_VAL(RESET_PC)) u_pc (
    .iClock(Clock), .iReset(Reset), .iEnable(w_redirect || w_fetch), .iD(w_pc_d), .oQ(r_pc));
  ff_async_en #(.WIDTH(INSN_WIDTH), .RST_VAL(BUBBLE)) u_insn (
    .iClock(Clock), .iReset(Reset), .iEnable(w_redirect || w_fetch), .iD(w_insn_d), .oQ(oInstruction));
  ff_async_en #(.WIDTH(ADDR_WIDTH), .RST_VAL('0)) u_insn_pc (
    .iClock(Clock), .iReset(Reset), .iEnable(w_fetch), .iD(r_pc), .oQ(oInstructionPC));
  ff_async_en #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
    .iClock(Clock), .iReset(Reset), .iEnable(w_redirect || w_fetch || w_xfer), .iD(w_fetch), .oQ(oValid));
`ifdef FETCH_PERF_EN
  ff_async_en #(.WIDTH(16), .RST_VAL(16'd0)) u_fetch_cnt (
    .iClock(Clock), .iReset(Reset), .iEnable(w_xfer), .iD(oFetchCount + 16'd1), .oQ(oFetchCount));
  ff_async_en #(.WIDTH(16), .RST_VAL(16'd0)) u_bubble_cnt (
    .iClock(Clock), .iReset(Reset), .iEnable(w_redirect), .iD(oBubbleCount + 16'd1), .oQ(oBubbleCount));
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table, hand sequences and randomized run against a reference model
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;
  localparam int AW = 16;
  localparam int IW = 28;
  localparam logic [IW-1:0] BUB = {NOP, 24'd0};
  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [AW-1:0] oAddress, oInstructionPC;
  logic [AW-1:0] iBranchTarget = '0;
  logic [IW-1:0] iInstruction, oInstruction;
  logic          oValid, oHalted;
  logic          iReady = 1'b1, iBranchTaken = 1'b0, iHalt = 1'b0, iResume = 1'b0;
`ifdef FETCH_PERF_EN
  logic [15:0]   oFetchCount, oBubbleCount;
`endif
  int n_checks = 0;
  int n_errors = 0;
  logic [AW-1:0] m_pc, m_ipc;
  logic [IW-1:0] m_insn;
  logic          m_valid;
  int            m_mode;
  int            m_fc, m_bc;
  typedef struct {
    logic rdy, br, halt, res;
    logic [AW-1:0] tgt;
    logic valid;
    logic [AW-1:0] ipc, addr;
    logic halted, bub;
  } vec_t;
  vec_t v[26];

  instruction_fetch dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
    .oInstruction(oInstruction), .oInstructionPC(oInstructionPC), .oValid(oValid),
    .iReady(iReady), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .iHalt(iHalt), .iResume(iResume), .oHalted(oHalted)
`ifdef FETCH_PERF_EN
    , .oFetchCount(oFetchCount), .oBubbleCount(oBubbleCount)
`endif
  );

  always #5 Clock = ~Clock;

  function automatic logic [IW-1:0] rom(logic [AW-1:0] a);
    return {12'hA5C, a};
  endfunction

  assign iInstruction = rom(oAddress);

  function automatic vec_t mk(logic rdy, logic br, logic [AW-1:0] tgt, logic halt, logic res,
                              logic valid, logic [AW-1:0] ipc, logic [AW-1:0] addr, logic halted, logic bub);
    vec_t r;
    r.rdy = rdy; r.br = br; r.tgt = tgt; r.halt = halt; r.res = res;
    r.valid = valid; r.ipc = ipc; r.addr = addr; r.halted = halted; r.bub = bub;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_ipc = '0; m_insn = BUB; m_valid = 1'b0; m_mode = 0; m_fc = 0; m_bc = 0;
  endtask

  // One clock of the fetch rules: 0 = booting, 1 = running, 2 = halted
  task automatic model_step();
    bit redir, xfer;
    redir = iBranchTaken && m_mode != 0;
    xfer  = m_valid && iReady;
    if (xfer) m_fc++;
    if (redir) begin
      m_bc++;
      m_pc = iBranchTarget; m_valid = 1'b0; m_insn = BUB;
    end else if (m_mode == 1 && (!m_valid || iReady)) begin
      m_insn = rom(m_pc); m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
    end else if (xfer) m_valid = 1'b0;
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) m_mode = (iHalt && !iBranchTaken) ? 2 : 1;
    else m_mode = (iResume && !iHalt) ? 1 : 2;
  endtask

  task automatic model_compare();
    check("m_valid", 32'(oValid), 32'(m_valid));
    check("m_addr", 32'(oAddress), 32'(m_pc));
    check("m_insn", 32'(oInstruction), 32'(m_insn));
    check("m_ipc", 32'(oInstructionPC), 32'(m_ipc));
    check("m_halted", 32'(oHalted), 32'(m_mode == 2));
`ifdef FETCH_PERF_EN
    check("m_fetch_cnt", 32'(oFetchCount), 32'(m_fc[15:0]));
    check("m_bubble_cnt", 32'(oBubbleCount), 32'(m_bc[15:0]));
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clock);
    #1;
    model_compare();
  endtask

  initial begin
    v[0]  = mk(1,0,16'h0,0,0,    0,16'h0,16'h0,0,1);
    v[1]  = mk(1,0,16'h0,0,0,    1,16'h0,16'h1,0,0);
    v[2]  = mk(1,0,16'h0,0,0,    1,16'h1,16'h2,0,0);
    v[3]  = mk(1,0,16'h0,0,0,    1,16'h2,16'h3,0,0);
    v[4]  = mk(0,0,16'h0,0,0,    1,16'h2,16'h3,0,0);
    v[5]  = mk(0,0,16'h0,0,0,    1,16'h2,16'h3,0,0);
    v[6]  = mk(0,0,16'h0,0,0,    1,16'h2,16'h3,0,0);
    v[7]  = mk(1,0,16'h0,0,0,    1,16'h3,16'h4,0,0);
    v[8]  = mk(1,0,16'h0,0,0,    1,16'h4,16'h5,0,0);
    v[9]  = mk(1,1,16'h8,0,0,    0,16'h4,16'h8,0,1);
    v[10] = mk(1,0,16'h0,0,0,    1,16'h8,16'h9,0,0);
    v[11] = mk(1,1,16'h2,1,0,    0,16'h8,16'h2,0,1);
    v[12] = mk(1,0,16'h0,0,0,    1,16'h2,16'h3,0,0);
    v[13] = mk(0,0,16'h0,1,0,    1,16'h2,16'h3,1,0);
    v[14] = mk(0,0,16'h0,0,0,    1,16'h2,16'h3,1,0);
    v[15] = mk(1,0,16'h0,0,0,    0,16'h2,16'h3,1,0);
    v[16] = mk(1,0,16'h0,0,1,    0,16'h2,16'h3,0,0);
    v[17] = mk(1,0,16'h0,0,0,    1,16'h3,16'h4,0,0);
    v[18] = mk(1,1,16'hFFFF,0,0, 0,16'h3,16'hFFFF,0,1);
    v[19] = mk(1,0,16'h0,0,0,    1,16'hFFFF,16'h0,0,0);
    v[20] = mk(1,0,16'h0,0,0,    1,16'h0,16'h1,0,0);
    v[21] = mk(1,0,16'h0,1,0,    1,16'h1,16'h2,1,0);
    v[22] = mk(0,0,16'h0,1,1,    1,16'h1,16'h2,1,0);
    v[23] = mk(0,1,16'h20,0,0,   0,16'h1,16'h20,1,1);
    v[24] = mk(1,0,16'h0,0,1,    0,16'h1,16'h20,0,1);
    v[25] = mk(1,0,16'h0,0,0,    1,16'h20,16'h21,0,0);
    model_reset();
    #2;
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_addr", 32'(oAddress), 32'd0);
    check("rst_insn", 32'(oInstruction), 32'(BUB));
    check("rst_ipc", 32'(oInstructionPC), 32'd0);
    check("rst_halted", 32'(oHalted), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 26; i++) begin
      iReady = v[i].rdy; iBranchTaken = v[i].br; iBranchTarget = v[i].tgt;
      iHalt = v[i].halt; iResume = v[i].res;
      cycle();
      check($sformatf("vec%0d_valid", i), 32'(oValid), 32'(v[i].valid));
      check($sformatf("vec%0d_ipc", i), 32'(oInstructionPC), 32'(v[i].ipc));
      check($sformatf("vec%0d_addr", i), 32'(oAddress), 32'(v[i].addr));
      check($sformatf("vec%0d_halted", i), 32'(oHalted), 32'(v[i].halted));
      check($sformatf("vec%0d_insn", i), 32'(oInstruction), 32'(v[i].bub ? BUB : rom(v[i].ipc)));
    end
    for (int i = 0; i < 400; i++) begin
      iReady = $urandom_range(3) != 0;
      iBranchTaken = $urandom_range(9) == 0;
      iBranchTarget = $urandom_range(1) != 0 ? 16'($urandom) : 16'hFFFE;
      iHalt = $urandom_range(19) == 0;
      iResume = $urandom_range(4) == 0;
      cycle();
    end
    iReady = 1'b1; iBranchTaken = 1'b0; iHalt = 1'b0; iResume = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    #3;
    Reset = 1'b1;
    #1;
    check("midrst_valid", 32'(oValid), 32'd0);
    check("midrst_addr", 32'(oAddress), 32'd0);
    check("midrst_insn", 32'(oInstruction), 32'(BUB));
    check("midrst_halted", 32'(oHalted), 32'd0);
`ifdef FETCH_PERF_EN
    check("midrst_fetch_cnt", 32'(oFetchCount), 32'd0);
`endif
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("post_rst_ipc", 32'(oInstructionPC), 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
